snn_config_scheduler: RTL and testbench
=======================================

// Module: snn_config_scheduler
// PURPOSE
//  Front-end controller for the delay-SNN datapath (24 in -> 8 hidden -> 2 out).
//  - Takes byte writes on a valid/ready port into a shadow configuration image:
//    weights, delays, threshold, decay, refractory period and input spikes.
//  - Copies the shadow image atomically into the active image that drives the SNN.
//  - Sequences the SNN: reset pulse, enable, and the per-timestep delay tick.
// PARAMETERS
//  N_IN        24  input spikes / synapses per hidden neuron
//  N_HID       8   hidden neurons
//  N_OUT       2   output neurons
//  W_BITS      2   bits per synaptic weight
//  D_BITS      4   bits per synaptic delay
//  P_BITS      6   threshold/decay/refractory width
//  TICK_DIV    4   clk cycles per SNN timestep (>=2)
//  RST_CYCLES  2   snn_reset pulse length after a commit from IDLE (>=1)
// PORTS
//  clk            in   1     system clock
//  rst_n          in   1     synchronous reset, active-low
//  in_valid       in   1     config write request
//  in_ready       out  1     write accepted when in_valid&&in_ready
//  in_addr        in   8     byte address (map below)
//  in_data        in   8     byte data
//  snn_reset      out  1     active-high reset to SNN datapath
//  snn_enable     out  1     SNN enable
//  delay_tick     out  1     1-cycle strobe per timestep, drives SNN delay_clk
//  weights        out  (N_IN*N_HID+N_HID*N_OUT)*W_BITS  active weights (416)
//  delays         out  (N_IN*N_HID+N_HID*N_OUT)*D_BITS  active delays (832)
//  threshold      out  P_BITS   active threshold
//  decay          out  P_BITS   active decay
//  refractory     out  P_BITS   active refractory period
//  input_spikes   out  N_IN     active input spikes
//  busy           out  1     state != IDLE
//  timestep       out  16    completed-timestep count, wraps at 2^16
//  addr_err       out  1     sticky: a write hit an unmapped address
// BEHAVIOUR
//  Reset (rst_n=0 at edge):
//  - state=IDLE; shadow/active images, counters, addr_err, pend_commit, run_req = 0.
//  - snn_reset=1; enable, tick and busy = 0; in_ready=1.
//  Address map (byte, LSB-first into each bus):
//  - 0x00-0x33 weights; 0x34-0x9B delays.
//  - 0x9C threshold; 0x9D decay; 0x9E refractory (bits >=P_BITS dropped).
//  - 0x9F-0xA1 input_spikes.
//  - 0xA2 CTRL: b0 commit, b1 run, b2 step, b3 clear_err; CTRL is not stored.
//  - 0xA3-0xFF unmapped: write accepted, discarded, addr_err<=1.
//  Write handshake:
//  - Shadow byte updates at the accepting edge.
//  - in_ready=0 only in COMMIT and SNN_RST.
//  - Active outputs are registered; they change only on a commit copy.
//  FSM IDLE/COMMIT/SNN_RST/RUN:
//  - IDLE: snn_enable=0, snn_reset=0.
//    CTRL commit -> COMMIT. Else run -> RUN. Else step -> RUN with one-shot set.
//  - COMMIT: 1 cycle; active<=shadow; -> SNN_RST.
//  - SNN_RST: snn_reset=1 for RST_CYCLES cycles.
//    Then RUN if the CTRL that committed had run or step, else IDLE.
//  - RUN: snn_enable=1; tick_cnt counts 0..TICK_DIV-1.
//    At tick_cnt==TICK_DIV-1: delay_tick=1, timestep++.
//    Leave RUN to IDLE on that tick cycle if run_req==0 or one-shot is set.
//    A CTRL write sets run_req<=b1.
//  - CTRL commit while in RUN sets pend_commit:
//    active<=shadow on the next tick edge, no snn_reset, pend_commit cleared.
//    A shadow write on that same edge is included in the copy (write first).
//  - Commit together with run/step in one CTRL byte: commit completes before RUN starts.
//  - step while in RUN is ignored.
//  - Entering RUN clears tick_cnt to 0.
//  - rst_n low mid-RUN or mid-COMMIT aborts at once to the reset values.
// STRUCTURE
//  - Package snn_cfg_pkg: N_*/W_BITS/D_BITS/P_BITS constants, address-map
//    localparams (ADDR_W_BASE, ADDR_D_BASE, ADDR_THR, ADDR_CTRL...), state enum.
//  - Sub-module snn_cfg_regfile: shadow byte array plus active copy on a
//    commit strobe. The FSM and tick counter stay in the top module.
// TESTING
//  1. Reset:
//     rst_n=0 for 2 cycles -> snn_reset=1, all active buses 0, in_ready=1, busy=0.
//  2. Load all weights=0, threshold=0x0A, spikes=0xFFFFFF, then CTRL=0x03:
//     - active buses change 1 cycle after accept;
//     - snn_reset high for 2 cycles, then snn_enable=1;
//     - delay_tick every 4th cycle; timestep=5 after 20 RUN cycles.
//  3. During RUN, write delays=all 0x22 and threshold=0x0B, then CTRL=0x03:
//     active buses stay old until the next delay_tick edge, then update;
//     snn_reset stays 0.
//  4. From IDLE, CTRL=0x04 -> exactly 4 cycles of snn_enable, one delay_tick,
//     timestep+1, back to IDLE.
//  5. Write addr 0xB0 -> addr_err=1, no bus changes; CTRL=0x08 -> addr_err=0.
//  6. Pull rst_n low during SNN_RST -> next cycle IDLE, active image 0,
//     in_ready=1, snn_reset=1.

Source files
------------

// File: rtl/snn_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_cfg_pkg
//  Description : Shared sizes, byte address map and FSM state encoding for
//                the delay-SNN configuration scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_cfg_pkg;

    // Network shape
    localparam int N_IN   = 24;
    localparam int N_HID  = 8;
    localparam int N_OUT  = 2;
    localparam int W_BITS = 2;
    localparam int D_BITS = 4;
    localparam int P_BITS = 6;

    // Derived bus widths
    localparam int N_SYN     = N_IN * N_HID + N_HID * N_OUT;  // 208 synapses
    localparam int WGT_BITS  = N_SYN * W_BITS;                 // 416
    localparam int DLY_BITS  = N_SYN * D_BITS;                 // 832
    localparam int WGT_BYTES = WGT_BITS / 8;                   // 52
    localparam int DLY_BYTES = DLY_BITS / 8;                   // 104
    localparam int SPK_BYTES = N_IN / 8;                       // 3

    // Byte address map
    localparam int ADDR_W_BASE   = 0;
    localparam int ADDR_D_BASE   = ADDR_W_BASE + WGT_BYTES;    // 0x34
    localparam int ADDR_THR      = ADDR_D_BASE + DLY_BYTES;    // 0x9C
    localparam int ADDR_DECAY    = ADDR_THR + 1;               // 0x9D
    localparam int ADDR_REFR     = ADDR_THR + 2;               // 0x9E
    localparam int ADDR_SPK_BASE = ADDR_THR + 3;               // 0x9F
    localparam int ADDR_CTRL     = ADDR_SPK_BASE + SPK_BYTES;  // 0xA2
    localparam int SHADOW_BYTES  = ADDR_CTRL;                  // stored bytes

    // CTRL byte bit positions
    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_RUN    = 1;
    localparam int CTRL_STEP   = 2;
    localparam int CTRL_CLR    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMMIT  = 2'd1,
        ST_SNN_RST = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/snn_cfg_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : snn_cfg_regfile
//  Description : Shadow configuration byte array plus the registered active
//                image, copied from the shadow on a commit strobe. A write on
//                the commit edge lands in the copy.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_cfg_regfile
    import snn_cfg_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [7:0]          wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                commit,
    output logic [WGT_BITS-1:0] weights,
    output logic [DLY_BITS-1:0] delays,
    output logic [P_BITS-1:0]   threshold,
    output logic [P_BITS-1:0]   decay,
    output logic [P_BITS-1:0]   refractory,
    output logic [N_IN-1:0]     input_spikes
);

    logic [7:0]          r_shadow [SHADOW_BYTES];
    logic [7:0]          w_next   [SHADOW_BYTES];
    logic [WGT_BITS-1:0] w_wgt;
    logic [DLY_BITS-1:0] w_dly;
    logic [N_IN-1:0]     w_spk;
    logic                w_unused;

    // Shadow contents after this cycle's write, so a commit sees the write
    always_comb begin
        for (int i = 0; i < SHADOW_BYTES; i++) begin
            w_next[i] = (wr_en && (wr_addr == 8'(i))) ? wr_data : r_shadow[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WGT_BYTES; gi++) begin : g_wgt_pack
            assign w_wgt[gi*8 +: 8] = w_next[ADDR_W_BASE + gi];
        end
        for (gi = 0; gi < DLY_BYTES; gi++) begin : g_dly_pack
            assign w_dly[gi*8 +: 8] = w_next[ADDR_D_BASE + gi];
        end
        for (gi = 0; gi < SPK_BYTES; gi++) begin : g_spk_pack
            assign w_spk[gi*8 +: 8] = w_next[ADDR_SPK_BASE + gi];
        end
    endgenerate

    // Upper bits of the parameter bytes are stored but never reach the SNN
    assign w_unused = ^{w_next[ADDR_THR][7:P_BITS], w_next[ADDR_DECAY][7:P_BITS],
                        w_next[ADDR_REFR][7:P_BITS]};

    // Shadow byte storage and atomic copy into the active image
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SHADOW_BYTES; i++) begin
                r_shadow[i] <= '0;
            end
            weights      <= '0;
            delays       <= '0;
            threshold    <= '0;
            decay        <= '0;
            refractory   <= '0;
            input_spikes <= '0;
        end else begin
            for (int i = 0; i < SHADOW_BYTES; i++) begin
                r_shadow[i] <= w_next[i];
            end
            if (commit) begin
                weights      <= w_wgt;
                delays       <= w_dly;
                threshold    <= w_next[ADDR_THR][P_BITS-1:0];
                decay        <= w_next[ADDR_DECAY][P_BITS-1:0];
                refractory   <= w_next[ADDR_REFR][P_BITS-1:0];
                input_spikes <= w_spk;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snn_config_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : snn_config_scheduler
//  Description : Byte-write configuration front end and run sequencer for the
//                delay-SNN datapath: commit, SNN reset pulse, enable and the
//                per-timestep delay tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_config_scheduler
    import snn_cfg_pkg::*;
#(
    parameter int TICK_DIV   = 4,
    parameter int RST_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_addr,
    input  logic [7:0]          in_data,
    output logic                snn_reset,
    output logic                snn_enable,
    output logic                delay_tick,
    output logic [WGT_BITS-1:0] weights,
    output logic [DLY_BITS-1:0] delays,
    output logic [P_BITS-1:0]   threshold,
    output logic [P_BITS-1:0]   decay,
    output logic [P_BITS-1:0]   refractory,
    output logic [N_IN-1:0]     input_spikes,
    output logic                busy,
    output logic [15:0]         timestep,
    output logic                addr_err
);

    localparam int TC_W = $clog2(TICK_DIV);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [TC_W-1:0] c_tick_last = TC_W'(TICK_DIV - 1);
    localparam logic [TC_W-1:0] c_tick_prev = TC_W'(TICK_DIV - 2);
    localparam logic [RC_W-1:0] c_rst_last  = RC_W'(RST_CYCLES - 1);

    state_t          r_state;
    logic [TC_W-1:0] r_tick_cnt;
    logic [RC_W-1:0] r_rst_cnt;
    logic [15:0]     r_timestep;
    logic            r_addr_err;
    logic            r_pend_commit;
    logic            r_run_req;
    logic            r_one_shot;
    logic            r_go_run;
    logic            r_snn_reset;
    logic            r_snn_enable;
    logic            r_delay_tick;
    logic            r_busy;
    logic            r_in_ready;

    logic w_accept;
    logic w_ctrl_wr;
    logic w_shadow_wr;
    logic w_unmapped;
    logic w_tick_edge;
    logic w_copy;

    assign w_accept    = in_valid && r_in_ready;
    assign w_ctrl_wr   = w_accept && (in_addr == 8'(ADDR_CTRL));
    assign w_shadow_wr = w_accept && (in_addr <  8'(ADDR_CTRL));
    assign w_unmapped  = w_accept && (in_addr >  8'(ADDR_CTRL));
    assign w_tick_edge = (r_state == ST_RUN) && (r_tick_cnt == c_tick_last);
    // Copy on the COMMIT cycle, or on the tick edge for a commit made in RUN
    assign w_copy      = (r_state == ST_COMMIT) || (w_tick_edge && r_pend_commit);

    snn_cfg_regfile u_regfile (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (w_shadow_wr),
        .wr_addr      (in_addr),
        .wr_data      (in_data),
        .commit       (w_copy),
        .weights      (weights),
        .delays       (delays),
        .threshold    (threshold),
        .decay        (decay),
        .refractory   (refractory),
        .input_spikes (input_spikes)
    );

    // Sequencer FSM with registered outputs set on each transition
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_tick_cnt    <= '0;
            r_rst_cnt     <= '0;
            r_timestep    <= '0;
            r_addr_err    <= 1'b0;
            r_pend_commit <= 1'b0;
            r_run_req     <= 1'b0;
            r_one_shot    <= 1'b0;
            r_go_run      <= 1'b0;
            r_snn_reset   <= 1'b1;
            r_snn_enable  <= 1'b0;
            r_delay_tick  <= 1'b0;
            r_busy        <= 1'b0;
            r_in_ready    <= 1'b1;
        end else begin
            if (w_ctrl_wr) begin
                r_run_req <= in_data[CTRL_RUN];
                if (in_data[CTRL_CLR]) begin
                    r_addr_err <= 1'b0;
                end
            end
            if (w_unmapped) begin
                r_addr_err <= 1'b1;
            end

            if (w_ctrl_wr && in_data[CTRL_COMMIT] && (r_state == ST_RUN)) begin
                r_pend_commit <= 1'b1;
            end else if (w_copy) begin
                r_pend_commit <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_snn_reset <= 1'b0;
                    if (w_ctrl_wr && in_data[CTRL_COMMIT]) begin
                        r_state    <= ST_COMMIT;
                        r_go_run   <= in_data[CTRL_RUN] || in_data[CTRL_STEP];
                        r_one_shot <= !in_data[CTRL_RUN] && in_data[CTRL_STEP];
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else if (w_ctrl_wr && (in_data[CTRL_RUN] || in_data[CTRL_STEP])) begin
                        r_state      <= ST_RUN;
                        r_one_shot   <= !in_data[CTRL_RUN];
                        r_tick_cnt   <= '0;
                        r_snn_enable <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_state     <= ST_SNN_RST;
                    r_snn_reset <= 1'b1;
                    r_rst_cnt   <= '0;
                end
                ST_SNN_RST: begin
                    if (r_rst_cnt == c_rst_last) begin
                        r_snn_reset <= 1'b0;
                        r_in_ready  <= 1'b1;
                        if (r_go_run) begin
                            r_state      <= ST_RUN;
                            r_tick_cnt   <= '0;
                            r_snn_enable <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_tick_cnt == c_tick_last) begin
                        r_tick_cnt   <= '0;
                        r_timestep   <= r_timestep + 16'd1;
                        r_delay_tick <= 1'b0;
                        if (!r_run_req || r_one_shot) begin
                            r_state      <= ST_IDLE;
                            r_snn_enable <= 1'b0;
                            r_busy       <= 1'b0;
                        end
                    end else begin
                        r_tick_cnt   <= r_tick_cnt + 1'b1;
                        r_delay_tick <= (r_tick_cnt == c_tick_prev);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign snn_reset  = r_snn_reset;
    assign snn_enable = r_snn_enable;
    assign delay_tick = r_delay_tick;
    assign busy       = r_busy;
    assign timestep   = r_timestep;
    assign addr_err   = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_snn_config_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snn_config_scheduler
//  Description : Self-checking bench for snn_config_scheduler. A byte-level
//                shadow model predicts each active image; predictions are
//                queued at commit time and compared when the DUT image changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_config_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_addr;
    logic [7:0]   in_data;
    logic         snn_reset;
    logic         snn_enable;
    logic         delay_tick;
    logic [415:0] weights;
    logic [831:0] delays;
    logic [5:0]   threshold;
    logic [5:0]   decay;
    logic [5:0]   refractory;
    logic [23:0]  input_spikes;
    logic         busy;
    logic [15:0]  timestep;
    logic         addr_err;

    snn_config_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .snn_reset    (snn_reset),
        .snn_enable   (snn_enable),
        .delay_tick   (delay_tick),
        .weights      (weights),
        .delays       (delays),
        .threshold    (threshold),
        .decay        (decay),
        .refractory   (refractory),
        .input_spikes (input_spikes),
        .busy         (busy),
        .timestep     (timestep),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [415:0] w;
        logic [831:0] d;
        logic [5:0]   t;
        logic [5:0]   dc;
        logic [5:0]   r;
        logic [23:0]  s;
    } exp_t;

    exp_t         sb[$];
    logic [7:0]   m_sh [0:161];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    logic         mon_en = 1'b0;
    logic [1289:0] cur;
    logic [1289:0] prev;

    assign cur = {weights, delays, threshold, decay, refractory, input_spikes};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [831:0] got, input logic [831:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 162; i++) m_sh[i] = 8'h00;
    endtask

    // Expected active image built from the shadow model
    task automatic push(input int c);
        exp_t e;
        e.cyc = c;
        for (int i = 0; i < 52; i++)  e.w[i*8 +: 8] = m_sh[i];
        for (int i = 0; i < 104; i++) e.d[i*8 +: 8] = m_sh[52 + i];
        e.t  = m_sh[156][5:0];
        e.dc = m_sh[157][5:0];
        e.r  = m_sh[158][5:0];
        e.s  = {m_sh[161], m_sh[160], m_sh[159]};
        sb.push_back(e);
    endtask

    // One write, driven from a negedge; returns at the negedge after acceptance
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("wr_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        if (a < 8'd162) m_sh[a] = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic int next_tick(input int j);
        int t = j + 1;
        while ((t % 4) != 3) t++;
        return t;
    endfunction

    // Active-image scoreboard: every change must match the oldest prediction
    always @(negedge clk) begin
        if (mon_en && (cur !== prev)) begin
            if (sb.size() == 0) begin
                check("img_unexpected_change", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("img_cycle", cyc, e.cyc);
                check("img_weights", weights, e.w);
                check("img_delays", delays, e.d);
                check("img_threshold", threshold, e.t);
                check("img_decay", decay, e.dc);
                check("img_refractory", refractory, e.r);
                check("img_spikes", input_spikes, e.s);
            end
            prev = cur;
        end
    end

    initial begin
        int run_start, jc, jd, je;
        logic [15:0] ts_model;
        logic saw_rst;
        logic [2:0] rst_seq;

        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        m_clear();

        // 1. reset state
        repeat (2) @(negedge clk);
        check("rst_snn_reset", snn_reset, 1);
        check("rst_ready_busy", {in_ready, busy, snn_enable, delay_tick}, 4'b1000);
        check("rst_weights", weights, 0);
        check("rst_delays", delays, 0);
        check("rst_params", {threshold, decay, refractory, input_spikes}, 0);
        check("rst_counters", {timestep, addr_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_snn_reset", snn_reset, 0);
        prev   = cur;
        mon_en = 1'b1;

        // 2. load, commit + run
        for (int i = 0; i < 52; i++) wr(8'(i), 8'h00);
        wr(8'h9C, 8'h0A);
        for (int i = 0; i < 3; i++) wr(8'(8'h9F + i), 8'hFF);
        wr(8'hA2, 8'h03);
        push(cyc + 1);
        check("commit_state", {in_ready, busy}, 2'b01);
        @(negedge clk); rst_seq[2] = snn_reset;
        @(negedge clk); rst_seq[1] = snn_reset;
        @(negedge clk); rst_seq[0] = snn_reset;
        check("snn_reset_pulse", rst_seq, 3'b110);
        run_start = cyc;
        for (int i = 0; i < 20; i++) begin
            check("run_tick", {snn_enable, delay_tick}, {1'b1, (i % 4) == 3});
            @(negedge clk);
        end
        check("run_timestep5", timestep, 5);

        // 3. writes and commit while running
        for (int i = 0; i < 104; i++) wr(8'(52 + i), 8'h22);
        wr(8'h9C, 8'h0B);
        wr(8'hA2, 8'h03);
        jc = cyc - 1 - run_start;
        push(run_start + next_tick(jc) + 1);
        wr(8'hA2, 8'h00);
        jd = cyc - 1 - run_start;
        je = next_tick(jd);
        saw_rst = 1'b0;
        while (cyc < run_start + je + 1) begin
            if (cyc == run_start + je) check("run_last_tick", {snn_enable, delay_tick}, 2'b11);
            saw_rst |= snn_reset;
            @(negedge clk);
        end
        check("run_no_snn_reset", saw_rst, 0);
        check("run_stop", {busy, snn_enable}, 0);
        ts_model = 16'((je + 1) / 4);
        check("run_timestep", timestep, ts_model);

        // 4. single step from IDLE
        wr(8'hA2, 8'h04);
        for (int i = 0; i < 4; i++) begin
            check("step_cycle", {snn_enable, delay_tick}, {1'b1, i == 3});
            @(negedge clk);
        end
        check("step_done", {busy, snn_enable}, 0);
        ts_model = ts_model + 16'd1;
        check("step_timestep", timestep, ts_model);

        // 5. unmapped write and clear
        wr(8'hB0, 8'h55);
        check("addr_err_set", addr_err, 1);
        wr(8'hA2, 8'h08);
        check("addr_err_clr", addr_err, 0);
        wr(8'hFF, 8'h01);
        check("addr_err_top", addr_err, 1);

        // 6. commit, then reset during SNN_RST
        wr(8'h9D, 8'h41);
        wr(8'h9E, 8'hFF);
        wr(8'h9C, 8'hFF);
        wr(8'hA2, 8'h01);
        push(cyc + 1);
        @(negedge clk);
        check("snnrst_state", {snn_reset, in_ready}, 2'b10);
        rst_n = 1'b0;
        m_clear();
        push(cyc + 1);
        @(negedge clk);
        check("abort_outputs", {snn_reset, in_ready, busy, snn_enable, delay_tick}, 5'b11000);
        check("abort_counters", {timestep, addr_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_idle", {snn_reset, busy}, 0);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
